// File: rtl/reg_sb_pkg.sv
// rtl/reg_sb_pkg.sv - shared modrm field layout, sizing defaults and register index type
//
// Purpose: constants and types shared by the register scoreboard and its
//          modrm destination decoder.
// Contents:
//   NREG_DEF, CNT_W_DEF  default scoreboard sizing
//   IDX_W                register index width (fixed at 3)
//   MOD_*/REG_*/RM_*     modrm bit positions
//   MOD_REG              mod value selecting the register-direct form
//   reg_idx_t            architectural register index
//   is_reg_direct()      true when modrm names a register in its rm field

package reg_sb_pkg;

  localparam int NREG_DEF  = 8;
  localparam int CNT_W_DEF = 3;
  localparam int IDX_W     = 3;

  // modrm = {mod[7:6], reg[5:3], rm[2:0]}
  localparam int MOD_HI = 7;
  localparam int MOD_LO = 6;
  localparam int REG_HI = 5;
  localparam int REG_LO = 3;
  localparam int RM_HI  = 2;
  localparam int RM_LO  = 0;

  localparam logic [1:0] MOD_REG = 2'b11;

  typedef logic [IDX_W-1:0] reg_idx_t;

  function automatic logic is_reg_direct(input logic [7:0] modrm);
    return modrm[MOD_HI:MOD_LO] == MOD_REG;
  endfunction

  function automatic reg_idx_t reg_field(input logic [7:0] modrm);
    return modrm[REG_HI:REG_LO];
  endfunction

  function automatic reg_idx_t rm_field(input logic [7:0] modrm);
    return modrm[RM_HI:RM_LO];
  endfunction

endpackage

// File: rtl/modrm_dest_decode.sv
// rtl/modrm_dest_decode.sv - destination register decode from a modrm byte
//
// Purpose: turn {modrm, rmsel, we} into the GPR written by an instruction.
//          Used identically at the issue point and at writeback so both
//          sides of the scoreboard agree on which counter to touch.
// Ports:
//   modrm  in   8  modrm byte
//   rmsel  in   1  0: destination is reg field, 1: destination is rm field
//   we     in   1  instruction writes a GPR
//   dest   out  3  destination register index
//   ldreg  out  1  a GPR is actually written

module modrm_dest_decode
  import reg_sb_pkg::*;
(
  input  logic [7:0] modrm,
  input  logic       rmsel,
  input  logic       we,
  output reg_idx_t   dest,
  output logic       ldreg
);

  always_comb begin
    dest  = reg_field(modrm);
    ldreg = we;
    if (rmsel) begin
      dest = rm_field(modrm);
      // A memory-form rm names an address base, not a written register.
      ldreg = we & is_reg_direct(modrm);
    end
  end

endmodule

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - in-flight GPR write tracker with decode hazard check and issue gating
//
// Purpose: counts outstanding writes per GPR between issue and writeback,
//          flags read-after-write hazards for the decode slot and decides
//          whether the decode instruction issues this cycle.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   q_v                          decode slot valid
//   q_ro_needed, q_rm_needed     decode reads reg / rm field register
//   q_modrm, q_we, q_rmsel       decode modrm, writes-GPR, destination select
//   stall                        downstream stall
//   wb_v, wb_we, wb_modrm,
//   wb_rmsel                     writeback destination description
//   flush                        synchronous clear of all counters
//   dep                          decode instruction has a RAW hazard
//   issue                        decode instruction accepted this cycle
//   pending[NREG]                registered "counter nonzero" per register
//   err_ovf                      sticky: issue blocked by a saturated counter
//   err_unf                      sticky: writeback hit a zero counter

module reg_scoreboard
  import reg_sb_pkg::*;
#(
  parameter int NREG  = NREG_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            q_v,
  input  logic            q_ro_needed,
  input  logic            q_rm_needed,
  input  logic [7:0]      q_modrm,
  input  logic            q_we,
  input  logic            q_rmsel,
  input  logic            stall,
  input  logic            wb_v,
  input  logic            wb_we,
  input  logic [7:0]      wb_modrm,
  input  logic            wb_rmsel,
  input  logic            flush,
  output logic            dep,
  output logic            issue,
  output logic [NREG-1:0] pending,
  output logic            err_ovf,
  output logic            err_unf
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CNT_W-1:0] cnt_q [NREG];
  logic [CNT_W-1:0] cnt_d [NREG];
  logic [NREG-1:0]  pending_q, pending_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;

  reg_idx_t iss_dest, wb_dest;
  logic     iss_ld, wb_ld;

  modrm_dest_decode u_iss_dec (
    .modrm (q_modrm),
    .rmsel (q_rmsel),
    .we    (q_we),
    .dest  (iss_dest),
    .ldreg (iss_ld)
  );

  modrm_dest_decode u_wb_dec (
    .modrm (wb_modrm),
    .rmsel (wb_rmsel),
    .we    (wb_we),
    .dest  (wb_dest),
    .ldreg (wb_ld)
  );

  // Hazard query reads only registered counters: no writeback bypass, and
  // an instruction's own write never makes it depend on itself.
  reg_idx_t ro_src, rm_src;
  logic     ro_busy, rm_busy, full, open_slot;

  always_comb begin
    ro_src  = reg_field(q_modrm);
    rm_src  = rm_field(q_modrm);
    ro_busy = q_ro_needed & (cnt_q[ro_src] != '0);
    rm_busy = q_rm_needed & is_reg_direct(q_modrm) & (cnt_q[rm_src] != '0);
    dep     = q_v & (ro_busy | rm_busy);
    full    = q_v & iss_ld & (cnt_q[iss_dest] == CNT_MAX);
    // Instruction would go if it weren't for its saturated destination.
    open_slot = q_v & ~stall & ~dep;
    issue   = open_slot & ~full & ~flush;
  end

  logic [NREG-1:0] inc_v, dec_v;
  logic            unf_hit;

  always_comb begin
    unf_hit = 1'b0;
    inc_v   = '0;
    dec_v   = '0;
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = cnt_q[r];
      inc_v[r] = issue & iss_ld & (iss_dest == r[IDX_W-1:0]);
      dec_v[r] = wb_v & wb_ld & (wb_dest == r[IDX_W-1:0]);
      if (flush) begin
        // Flush discards this cycle's issue and writeback entirely.
        cnt_d[r] = '0;
      end else if (inc_v[r] && !dec_v[r]) begin
        cnt_d[r] = cnt_q[r] + 1'b1;
      end else if (dec_v[r] && !inc_v[r]) begin
        if (cnt_q[r] != '0) begin
          cnt_d[r] = cnt_q[r] - 1'b1;
        end else begin
          unf_hit = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pending_d = '0;
    for (int r = 0; r < NREG; r++) begin
      pending_d[r] = (cnt_d[r] != '0);
    end
    err_ovf_d = err_ovf_q | (open_slot & full);
    err_unf_d = err_unf_q | unf_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
      pending_q <= '0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      for (int r = 0; r < NREG; r++) begin
        cnt_q[r] <= cnt_d[r];
      end
      pending_q <= pending_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign pending = pending_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - self-checking bench for reg_scoreboard

module tb_reg_scoreboard;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       q_v, q_ro_needed, q_rm_needed, q_we, q_rmsel, stall;
  logic [7:0] q_modrm;
  logic       wb_v, wb_we, wb_rmsel, flush;
  logic [7:0] wb_modrm;
  logic       dep, issue, err_ovf, err_unf;
  logic [7:0] pending;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .q_v         (q_v),
    .q_ro_needed (q_ro_needed),
    .q_rm_needed (q_rm_needed),
    .q_modrm     (q_modrm),
    .q_we        (q_we),
    .q_rmsel     (q_rmsel),
    .stall       (stall),
    .wb_v        (wb_v),
    .wb_we       (wb_we),
    .wb_modrm    (wb_modrm),
    .wb_rmsel    (wb_rmsel),
    .flush       (flush),
    .dep         (dep),
    .issue       (issue),
    .pending     (pending),
    .err_ovf     (err_ovf),
    .err_unf     (err_unf)
  );

  typedef struct {
    bit       v, ro, rm;
    bit [7:0] modrm;
    bit       we, rmsel, stall, wbv, wbwe;
    bit [7:0] wbmodrm;
    bit       wbrmsel, flush;
    bit       edep, eiss;
    bit [7:0] epend;
    bit       eovf, eunf;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit ro, input bit rm, input bit [7:0] modrm,
                       input bit we, input bit rmsel, input bit st, input bit wbv,
                       input bit wbwe, input bit [7:0] wbmodrm, input bit wbrmsel,
                       input bit fl);
    q_v = v; q_ro_needed = ro; q_rm_needed = rm; q_modrm = modrm;
    q_we = we; q_rmsel = rmsel; stall = st;
    wb_v = wbv; wb_we = wbwe; wb_modrm = wbmodrm; wb_rmsel = wbrmsel; flush = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 8'h00, 0, 0);
  endtask

  task automatic add(input bit v, input bit ro, input bit rm, input bit [7:0] modrm,
                     input bit we, input bit rmsel, input bit st, input bit wbv,
                     input bit wbwe, input bit [7:0] wbmodrm, input bit wbrmsel,
                     input bit fl, input bit edep, input bit eiss, input bit [7:0] epend,
                     input bit eovf, input bit eunf);
    vec_t e;
    e.v = v; e.ro = ro; e.rm = rm; e.modrm = modrm; e.we = we; e.rmsel = rmsel;
    e.stall = st; e.wbv = wbv; e.wbwe = wbwe; e.wbmodrm = wbmodrm;
    e.wbrmsel = wbrmsel; e.flush = fl; e.edep = edep; e.eiss = eiss;
    e.epend = epend; e.eovf = eovf; e.eunf = eunf;
    tbl.push_back(e);
  endtask

  // Reference model: counts of in-flight writes per register, plus sticky flags.
  int mc[8];
  bit m_ovf, m_unf;

  function automatic int dest_of(input bit [7:0] modrm, input bit rmsel);
    return rmsel ? (modrm % 8) : ((modrm / 8) % 8);
  endfunction

  function automatic bit writes(input bit [7:0] modrm, input bit rmsel, input bit we);
    return we && (!rmsel || modrm >= 8'd192);
  endfunction

  function automatic bit m_dep();
    int ro_r = (q_modrm / 8) % 8;
    int rm_r = q_modrm % 8;
    return q_v && ((q_ro_needed && mc[ro_r] > 0) ||
                   (q_rm_needed && q_modrm >= 8'd192 && mc[rm_r] > 0));
  endfunction

  function automatic bit m_full();
    return q_v && writes(q_modrm, q_rmsel, q_we) && mc[dest_of(q_modrm, q_rmsel)] == 7;
  endfunction

  function automatic bit [7:0] m_pend();
    bit [7:0] p = '0;
    for (int r = 0; r < 8; r++) p[r] = (mc[r] > 0);
    return p;
  endfunction

  task automatic model_clock();
    bit d = m_dep();
    bit f = m_full();
    bit iss = q_v && !stall && !d && !f && !flush;
    if (q_v && !stall && !d && f) m_ovf = 1;
    if (flush) begin
      for (int r = 0; r < 8; r++) mc[r] = 0;
    end else begin
      if (iss && writes(q_modrm, q_rmsel, q_we)) mc[dest_of(q_modrm, q_rmsel)]++;
      if (wb_v && writes(wb_modrm, wb_rmsel, wb_we)) begin
        if (mc[dest_of(wb_modrm, wb_rmsel)] > 0) mc[dest_of(wb_modrm, wb_rmsel)]--;
        else m_unf = 1;
      end
    end
  endtask

  task automatic model_reset();
    for (int r = 0; r < 8; r++) mc[r] = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    #12;
    chk("reset_pending", pending, 0);
    chk("reset_ovf", err_ovf, 0);
    chk("reset_unf", err_unf, 0);
    chk("reset_dep", dep, 0);
    chk("reset_issue", issue, 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // v ro rm modrm we rs st wbv wbwe wbm wbrs fl | dep iss pend ovf unf
    add(1,1,0,8'hC8,0,0,0,0,0,8'h00,0,0, 0,1,8'h00,0,0);
    add(1,0,0,8'hD8,1,0,0,0,0,8'h00,0,0, 0,1,8'h00,0,0);
    add(1,0,1,8'hC3,0,0,0,0,0,8'h00,0,0, 1,0,8'h08,0,0);
    add(1,1,0,8'hD8,0,0,0,0,0,8'h00,0,0, 1,0,8'h08,0,0);
    add(0,0,0,8'h00,0,0,0,1,1,8'hD8,0,0, 0,0,8'h08,0,0);
    add(1,0,1,8'hC3,0,0,0,0,0,8'h00,0,0, 0,1,8'h00,0,0);
    add(1,0,0,8'h05,1,1,0,0,0,8'h00,0,0, 0,1,8'h00,0,0);
    add(1,0,1,8'h05,0,0,0,0,0,8'h00,0,0, 0,1,8'h00,0,0);
    add(1,0,0,8'hD0,1,0,0,0,0,8'h00,0,0, 0,1,8'h00,0,0);
    add(1,0,0,8'hD0,1,0,0,1,1,8'hD0,0,0, 0,1,8'h04,0,0);
    add(0,0,0,8'h00,0,0,0,0,0,8'h00,0,0, 0,0,8'h04,0,0);
    add(0,0,0,8'h00,0,0,0,0,0,8'h00,0,1, 0,0,8'h04,0,0);
    add(1,0,0,8'hC0,1,0,1,0,0,8'h00,0,0, 0,0,8'h00,0,0);
    for (int k = 0; k < 7; k++)
      add(1,0,0,8'hC0,1,0,0,0,0,8'h00,0,0, 0,1,(k == 0) ? 8'h00 : 8'h01,0,0);
    add(1,0,0,8'hC0,1,0,0,0,0,8'h00,0,0, 0,0,8'h01,0,0);
    add(0,0,0,8'h00,0,0,0,0,0,8'h00,0,0, 0,0,8'h01,1,0);
    add(0,0,0,8'h00,0,0,0,1,1,8'hE8,0,0, 0,0,8'h01,1,0);
    add(0,0,0,8'h00,0,0,0,0,0,8'h00,0,0, 0,0,8'h01,1,1);
    add(0,0,0,8'h00,0,0,0,0,0,8'h00,0,0, 0,0,8'h01,1,1);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].ro, tbl[i].rm, tbl[i].modrm, tbl[i].we, tbl[i].rmsel,
            tbl[i].stall, tbl[i].wbv, tbl[i].wbwe, tbl[i].wbmodrm, tbl[i].wbrmsel,
            tbl[i].flush);
      #3;
      chk($sformatf("tbl%0d_dep", i), dep, tbl[i].edep);
      chk($sformatf("tbl%0d_issue", i), issue, tbl[i].eiss);
      chk($sformatf("tbl%0d_pending", i), pending, tbl[i].epend);
      chk($sformatf("tbl%0d_ovf", i), err_ovf, tbl[i].eovf);
      chk($sformatf("tbl%0d_unf", i), err_unf, tbl[i].eunf);
      @(posedge clk);
      #1;
    end

    // Asynchronous reset between edges clears state before the next edge.
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_pending", pending, 0);
    chk("async_rst_ovf", err_ovf, 0);
    chk("async_rst_unf", err_unf, 0);
    chk("async_rst_issue", issue, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    // A writeback left over from before reset now counts as underflow.
    drive(0, 0, 0, 8'h00, 0, 0, 0, 1, 1, 8'hC1, 1, 0);
    @(posedge clk);
    #1;
    idle();
    #3;
    chk("post_rst_unf", err_unf, 1);
    chk("post_rst_pending", pending, 0);
    @(posedge clk);
    #1;

    // Self-dependence: reads and writes reg 4; issues, then a copy stalls on it.
    drive(1, 1, 0, 8'hE0, 1, 0, 0, 0, 0, 8'h00, 0, 0);
    #3;
    chk("self_dep_first", dep, 0);
    chk("self_issue_first", issue, 1);
    @(posedge clk);
    #1;
    #3;
    chk("self_dep_second", dep, 1);
    chk("self_pending", pending, 8'h10);
    @(posedge clk);
    #1;

    // Randomized phase against the reference model.
    do_reset();
    for (int n = 0; n < 1500; n++) begin
      bit [7:0] m  = 8'($urandom);
      bit [7:0] wm = 8'($urandom);
      if ($urandom_range(1, 0) == 1) m[5:3] = 3'($urandom_range(1, 0));
      if ($urandom_range(3, 0) != 0) wm[7:6] = 2'b11;
      drive($urandom_range(9, 0) < 8, 1'($urandom), 1'($urandom), m,
            $urandom_range(3, 0) != 0, 1'($urandom), $urandom_range(9, 0) < 2,
            $urandom_range(9, 0) < 3, 1'($urandom), wm, 1'($urandom),
            $urandom_range(99, 0) < 3);
      #3;
      chk("rnd_dep", dep, m_dep());
      chk("rnd_issue", issue, q_v && !stall && !m_dep() && !m_full() && !flush);
      chk("rnd_pending", pending, m_pend());
      chk("rnd_ovf", err_ovf, m_ovf);
      chk("rnd_unf", err_unf, m_unf);
      model_clock();
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
